xunit_msched: RTL
=================

XUNIT_MSCHED -- requirements
Module: xunit_msched

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  clock, rising-edge active.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port run  input  1  synchronous start pulse, sampled on rising clk.
REQ-005 SHALL have port done  output  1  high when unit idle/finished.
REQ-006 SHALL have port configdata  input  8  start delay in cycles, latched on run.
REQ-007 SHALL have port in0  input  DATA_W  message word stream M_0..M_15, one word per STREAM cycle.
REQ-008 SHALL have port out0  output  DATA_W  registered schedule word W_t, feeds the compression unit's w input.
REQ-009 SHALL have port out1  output  DATA_W  registered round constant K_t, feeds the compression unit's k input.
REQ-010 SHALL have port out2  output  1  registered valid, high while out0/out1 hold W_t/K_t of the current block.

Function
REQ-011 SHALL implement states IDLE, DELAY, STREAM, DONE; done = 1 in IDLE and DONE, 0 otherwise.
REQ-012 run=1 in any state SHALL latch configdata into the delay counter, clear round counter t to 0, clear out2, and enter DELAY (configdata>1) or STREAM (configdata 0 or 1).
REQ-013 DELAY: counter decrements once per cycle; the edge on which counter==1 SHALL move to STREAM.
REQ-014 STREAM, t in 0..15: on the edge, the unit SHALL register W_t = in0 into out0 and into window slot 15, shifting window slots 15..1 down by one (slot 0 discarded).
REQ-015 STREAM, t in 16..63: W_t SHALL equal sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], mod 2^32, registered into out0 and window slot 15 with the same shift; in0 ignored.
REQ-016 sigma0(x) SHALL be ROTR7^ROTR18^SHR3; sigma1(x) SHALL be ROTR17^ROTR19^SHR10; all adds SHALL be 32-bit with carry-out discarded.
REQ-017 out1 SHALL be registered on the same edge as out0 from an internal 64-entry ROM holding the FIPS 180-4 SHA-256 constants, K_0=0x428a2f98 .. K_63=0xc67178f2.
REQ-018 out2 SHALL be 1 for exactly the 64 cycles following the 64 STREAM edges; t increments each STREAM edge.
REQ-019 The edge with t==63 SHALL enter DONE; out0/out1 SHALL hold W_63/K_63, out2 SHALL clear on the next edge.
REQ-020 run asserted in STREAM or DELAY SHALL abort the current block and restart per REQ-012; the window is not cleared, and is fully overwritten by t=15.
REQ-021 Latency: with configdata=D>=1, the first valid W_0 SHALL appear on out0 D cycles after the run edge; with D=0, one cycle after it.
REQ-022 In IDLE/DONE, out0/out1/window SHALL hold their values.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, delay counter 0, t 0, window all 0, out0 0, out1 0, out2 0, done 1.
REQ-024 rst asserted mid-STREAM SHALL abort the block with no further valid output until a new run.

Verification
REQ-025 Reset: assert rst mid-operation -> out0=0, out1=0, out2=0, done=1 asynchronously.
REQ-026 "abc" block: run with configdata=1, in0 = 0x61626380, 14 x 0x00000000, 0x00000018 -> W_0=0x61626380, W_16=0x61626380, W_17=0x000F0000, out1 first 0x428a2f98, last 0xc67178f2, out2 high 64 cycles.
REQ-027 Delay: configdata=5 -> done drops on the run edge, first out2=1 exactly 5 cycles after run, done=1 after 64 valid cycles.
REQ-028 configdata=0 -> behaves as configdata=1 (first valid one cycle after run).
REQ-029 Restart: assert run at t=30, then feed a new block -> out2 drops, output sequence restarts at W_0 of the new block, with no stale words from the first block.
REQ-030 Random blocks: check 64 W_t words against a software reference for 1000 random 512-bit blocks back-to-back (run issued in DONE).

Source files
------------

// File: rtl/xunit_msched.sv
// xunit_msched: SHA-256 message scheduler. Streams W_0..W_63 and K_0..K_63
// to the compression unit, one pair per cycle, after a programmable delay.
//
// Ports:
//   clk         clock, rising-edge active
//   rst         asynchronous, active-high reset
//   run         start pulse; restarts the block from any state
//   configdata  start delay in cycles, latched on run
//   in0         message words M_0..M_15, sampled on the first 16 stream edges
//   done        high while idle or finished
//   out0        schedule word W_t
//   out1        round constant K_t
//   out2        valid for out0/out1
module xunit_msched #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [7:0]        configdata,
  input  logic [DATA_W-1:0] in0,
  output logic              done,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic              out2
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned T_W    = 6;
  localparam int unsigned WIN_N  = 16;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_STREAM,
    S_DONE
  } state_e;

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (DATA_W - n));
  endfunction

  function automatic logic [DATA_W-1:0] sig0(input logic [DATA_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [DATA_W-1:0] sig1(input logic [DATA_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [T_W-1:0]      t_q, t_d;
  logic [DATA_W-1:0]   win_q [WIN_N];
  logic [DATA_W-1:0]   win_d [WIN_N];
  logic [DATA_W-1:0]   out0_q, out0_d;
  logic [DATA_W-1:0]   out1_q, out1_d;
  logic                out2_q, out2_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   w_new;

  // Next schedule word: raw message for t<16, expansion recurrence after.
  always_comb begin
    w_new = in0;
    if (t_q >= T_W'(16)) begin
      w_new = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    win_d   = win_q;
    out0_d  = out0_q;
    out1_d  = out1_q;
    out2_d  = 1'b0;

    if (run) begin
      cnt_d   = configdata;
      t_d     = '0;
      state_d = (configdata > CNT_W'(1)) ? S_DELAY : S_STREAM;
    end else begin
      case (state_q)
        S_DELAY: begin
          // Leave on the edge that brings the counter to 1, so W_0 lands
          // exactly D cycles after the run edge.
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(2)) begin
            state_d = S_STREAM;
          end
        end
        S_STREAM: begin
          for (int i = 0; i < WIN_N - 1; i++) begin
            win_d[i] = win_q[i+1];
          end
          win_d[WIN_N-1] = w_new;
          out0_d = w_new;
          out1_d = K_TAB[t_q];
          out2_d = 1'b1;
          t_d    = t_q + T_W'(1);
          if (t_q == T_W'(63)) begin
            state_d = S_DONE;
          end
        end
        default: begin
        end
      endcase
    end

    done_d = (state_d == S_IDLE) || (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      t_q     <= '0;
      for (int i = 0; i < WIN_N; i++) begin
        win_q[i] <= '0;
      end
      out0_q  <= '0;
      out1_q  <= '0;
      out2_q  <= 1'b0;
      done_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      for (int i = 0; i < WIN_N; i++) begin
        win_q[i] <= win_d[i];
      end
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      done_q  <= done_d;
    end
  end

  assign out0 = out0_q;
  assign out1 = out1_q;
  assign out2 = out2_q;
  assign done = done_q;

endmodule
